icache_direct_mapped: RTL and testbench

Direct-mapped, read-only instruction cache that answers the fetch stage's instruction requests. On a hit it returns the instruction combinationally. On a miss it asserts a stall and refills the whole line word-by-word from instruction memory through a req/valid handshake.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/icache_tag_array.sv | 43 ++++
 rtl/icache_direct_mapped.sv | 170 +++++++++++++++++
 tb/tb_icache_direct_mapped.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package cpu_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned INDEX_BITS     = 4;
  localparam int unsigned OFFSET_BITS    = 2;
  localparam int unsigned LINES          = 1 << INDEX_BITS;
  localparam int unsigned WORDS          = 1 << OFFSET_BITS;
  localparam int unsigned TAG_BITS       = XLEN - INDEX_BITS - OFFSET_BITS - 2;
  localparam int unsigned DATA_ADDR_BITS = INDEX_BITS + OFFSET_BITS;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_e;

  // Word address split into cache fields (byte offset dropped).
  typedef struct packed {
    logic [TAG_BITS-1:0]    tag;
    logic [INDEX_BITS-1:0]  index;
    logic [OFFSET_BITS-1:0] word;
  } icache_addr_t;

  // Extract the cache fields from a byte address.
  function automatic icache_addr_t split_addr(input logic [XLEN-1:0] addr);
    return icache_addr_t'(addr[XLEN-1:2]);
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid/tag storage: combinational lookup, single-line install, flash clear.
module icache_tag_array
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] i_lookup_index,
  input  logic [TAG_BITS-1:0]   i_lookup_tag,
  output logic                  o_hit_c,
  input  logic                  i_clear,
  input  logic                  i_install,
  input  logic [INDEX_BITS-1:0] i_install_index,
  input  logic [TAG_BITS-1:0]   i_install_tag,
  input  logic                  i_install_valid
);

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag [LINES];

  // Valid bits: flash clear first, then install may set/clear one line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      if (i_clear) begin
        r_valid <= '0;
      end
      if (i_install) begin
        r_valid[i_install_index] <= i_install_valid;
      end
    end
  end

  // Tag storage is never reset; the valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (i_install) begin
      r_tag[i_install_index] <= i_install_tag;
    end
  end

  assign o_hit_c = r_valid[i_lookup_index] && (r_tag[i_lookup_index] == i_lookup_tag);

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with word-by-word line refill.
// Optional hit/miss performance counters are built when ICACHE_PERF_EN is defined.
module icache_direct_mapped
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] Addr,
  output logic [XLEN-1:0] Inst,
  output logic            ICacheStall,
  input  logic            Flush,
  output logic            MemReq,
  output logic [XLEN-1:0] MemPc,
  input  logic [XLEN-1:0] MemInst,
  input  logic            MemValid
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]     HitCount,
  output logic [31:0]     MissCount
`endif
);

  icache_state_e          r_state;
  icache_state_e          w_state_next;
  logic [TAG_BITS-1:0]    r_miss_tag;
  logic [INDEX_BITS-1:0]  r_miss_index;
  logic [OFFSET_BITS-1:0] r_cnt;
  logic                   r_drop;
  logic [XLEN-1:0]        r_data [LINES*WORDS];

  icache_addr_t           w_addr;
  logic                   w_tag_hit_c;
  logic                   w_hit;
  logic                   w_last_word;
  logic                   w_beat;
  logic                   w_install;
  logic                   w_unused_ok;

  assign w_addr      = split_addr(Addr);
  assign w_unused_ok = ^Addr[1:0];
  assign w_hit       = w_tag_hit_c && !Flush;
  assign w_last_word = (r_cnt == OFFSET_BITS'(WORDS - 1));
  assign w_beat      = (r_state == REFILL) && MemValid;
  assign w_install   = w_beat && w_last_word;

  icache_tag_array u_tags (
    .clk             (clk),
    .rst_n           (rst),
    .i_lookup_index  (w_addr.index),
    .i_lookup_tag    (w_addr.tag),
    .o_hit_c         (w_tag_hit_c),
    .i_clear         (Flush),
    .i_install       (w_install),
    .i_install_index (r_miss_index),
    .i_install_tag   (r_miss_tag),
    .i_install_valid (!(r_drop || Flush))
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: miss starts a refill, last accepted word ends it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!w_hit) w_state_next = REFILL;
      REFILL:  if (w_install) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs: hit data in IDLE, memory request in REFILL, quiet in reset.
  always_comb begin
    Inst        = NOP_INST;
    ICacheStall = 1'b0;
    MemReq      = 1'b0;
    MemPc       = '0;
    if (rst) begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            Inst = r_data[{w_addr.index, w_addr.word}];
          end else begin
            ICacheStall = 1'b1;
          end
        end
        REFILL: begin
          ICacheStall = 1'b1;
          MemReq      = 1'b1;
          MemPc       = {r_miss_tag, r_miss_index, r_cnt, 2'b00};
        end
        default: begin
          ICacheStall = 1'b0;
        end
      endcase
    end
  end

  // Miss registers, word counter and drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miss_tag   <= '0;
      r_miss_index <= '0;
      r_cnt        <= '0;
      r_drop       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_hit) begin
            r_miss_tag   <= w_addr.tag;
            r_miss_index <= w_addr.index;
            r_cnt        <= '0;
            r_drop       <= 1'b0;
          end
        end
        REFILL: begin
          if (Flush) begin
            r_drop <= 1'b1;
          end
          if (MemValid) begin
            r_cnt <= r_cnt + OFFSET_BITS'(1);
          end
          if (w_install) begin
            r_drop <= 1'b0;
          end
        end
        default: begin
          r_drop <= 1'b0;
        end
      endcase
    end
  end

  // Data array write, one word per accepted memory beat.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_data[{r_miss_index, r_cnt}] <= MemInst;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Saturating hit/miss counters; Flush does not touch them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == IDLE) begin
      if (w_hit && !ICacheStall) begin
        if (r_hit_count != 32'hFFFF_FFFF) r_hit_count <= r_hit_count + 32'd1;
      end
      if (!w_hit) begin
        if (r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign HitCount  = r_hit_count;
  assign MissCount = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped with a wait-state memory model.
// Memory word at byte address a holds 32'hA0 + (a >> 2).
module tb_icache_direct_mapped;

  logic        clk;
  logic        rst;
  logic [31:0] Addr;
  logic [31:0] Inst;
  logic        ICacheStall;
  logic        Flush;
  logic        MemReq;
  logic [31:0] MemPc;
  logic [31:0] MemInst;
  logic        MemValid;
`ifdef ICACHE_PERF_EN
  logic [31:0] HitCount;
  logic [31:0] MissCount;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int mem_wait = 0;
  int mem_wcnt = 0;

  logic [31:0] acc[$];
  int          stab_err;
  int          n_stall;

  icache_direct_mapped dut (
    .clk         (clk),
    .rst         (rst),
    .Addr        (Addr),
    .Inst        (Inst),
    .ICacheStall (ICacheStall),
    .Flush       (Flush),
    .MemReq      (MemReq),
    .MemPc       (MemPc),
    .MemInst     (MemInst),
    .MemValid    (MemValid)
`ifdef ICACHE_PERF_EN
    ,
    .HitCount    (HitCount),
    .MissCount   (MissCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: answers after mem_wait idle cycles per word.
  always @(negedge clk) begin
    if (MemReq) begin
      if (mem_wcnt == mem_wait) begin
        MemValid = 1'b1;
        MemInst  = 32'hA0 + (MemPc >> 2);
        mem_wcnt = 0;
      end else begin
        MemValid = 1'b0;
        mem_wcnt = mem_wcnt + 1;
      end
    end else begin
      MemValid = 1'b0;
      mem_wcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, settle, then caller samples.
  task automatic cyc(input logic [31:0] a, input logic f);
    @(negedge clk);
    rst   = 1'b1;
    Addr  = a;
    Flush = f;
    #1;
  endtask

  // Hold Addr until the stall drops; count stall cycles, log accepted words.
  task automatic wait_fill(input logic [31:0] a);
    logic        prev_req;
    logic        prev_acc;
    logic [31:0] prev_pc;
    int          guard;
    acc.delete();
    stab_err = 0;
    n_stall  = 0;
    prev_req = 1'b0;
    prev_acc = 1'b0;
    prev_pc  = '0;
    guard    = 0;
    do begin
      cyc(a, 1'b0);
      guard++;
      if (ICacheStall) n_stall++;
      if (MemReq && prev_req && !prev_acc && (MemPc != prev_pc)) stab_err++;
      if (MemReq && MemValid) acc.push_back(MemPc);
      prev_req = MemReq;
      prev_acc = MemReq && MemValid;
      prev_pc  = MemPc;
    end while (ICacheStall && guard < 200);
    chk("fill_ready", {31'd0, ICacheStall}, 32'd0);
  endtask

  task automatic chk_words(input string tag, input logic [31:0] base);
    chk({tag, "_nwords"}, 32'(acc.size()), 32'd4);
    for (int i = 0; i < acc.size() && i < 4; i++) begin
      chk({tag, "_pc"}, acc[i], base + 32'(4 * i));
    end
  endtask

  initial begin
    rst      = 1'b0;
    Addr     = 32'h0;
    Flush    = 1'b0;
    MemInst  = '0;
    MemValid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    // Reset state
    chk("rst_inst",  Inst, 32'h0000_0013);
    chk("rst_stall", {31'd0, ICacheStall}, 32'd0);
    chk("rst_req",   {31'd0, MemReq}, 32'd0);
    chk("rst_pc",    MemPc, 32'd0);

    // Cold miss on line 0
    wait_fill(32'h0);
    chk("cold_stall", 32'(n_stall), 32'd5);
    chk("cold_inst",  Inst, 32'hA0);
    chk_words("cold", 32'h0);

    // Hits on the rest of the line
    cyc(32'h4, 1'b0);
    chk("hit4_inst", Inst, 32'hA1);
    chk("hit4_stall", {31'd0, ICacheStall}, 32'd0);
    chk("hit4_req", {31'd0, MemReq}, 32'd0);
    cyc(32'h8, 1'b0);
    chk("hit8_inst", Inst, 32'hA2);
    chk("hit8_stall", {31'd0, ICacheStall}, 32'd0);
    cyc(32'hC, 1'b0);
    chk("hitC_inst", Inst, 32'hA3);
    chk("hitC_stall", {31'd0, ICacheStall}, 32'd0);

    // Conflict eviction at index 0
    wait_fill(32'h100);
    chk("evict_stall", 32'(n_stall), 32'd5);
    chk("evict_inst",  Inst, 32'hE0);
    chk_words("evict", 32'h100);
    wait_fill(32'h0);
    chk("back0_stall", 32'(n_stall), 32'd5);
    chk("back0_inst",  Inst, 32'hA0);

    // Two wait states per word
    mem_wait = 2;
    wait_fill(32'h40);
    chk("wait_stall", 32'(n_stall), 32'd13);
    chk("wait_inst",  Inst, 32'hB0);
    chk("wait_stable", 32'(stab_err), 32'd0);
    chk_words("wait", 32'h40);
    mem_wait = 0;

    // Flush on the second refill word of 0x80
    cyc(32'h80, 1'b0);
    chk("fl_miss_stall", {31'd0, ICacheStall}, 32'd1);
    cyc(32'h80, 1'b0);
    chk("fl_w0_pc", MemPc, 32'h80);
    cyc(32'h80, 1'b1);
    chk("fl_w1_pc", MemPc, 32'h84);
    chk("fl_w1_req", {31'd0, MemReq}, 32'd1);
    cyc(32'h80, 1'b0);
    cyc(32'h80, 1'b0);
    chk("fl_w3_pc", MemPc, 32'h8C);
    chk("fl_w3_inst", Inst, 32'h0000_0013);
    cyc(32'h80, 1'b0);
    chk("fl_refetch_stall", {31'd0, ICacheStall}, 32'd1);
    chk("fl_refetch_req", {31'd0, MemReq}, 32'd0);
    wait_fill(32'h80);
    chk("fl_refill_stall", 32'(n_stall), 32'd4);
    chk("fl_refill_inst", Inst, 32'hC0);
    cyc(32'h84, 1'b0);
    chk("fl_hit84_inst", Inst, 32'hC1);
    chk("fl_hit84_stall", {31'd0, ICacheStall}, 32'd0);

    // Flush in IDLE turns a would-be hit into a miss
    cyc(32'h84, 1'b1);
    chk("fi_stall", {31'd0, ICacheStall}, 32'd1);
    chk("fi_inst", Inst, 32'h0000_0013);
    wait_fill(32'h84);
    chk("fi_refill_stall", 32'(n_stall), 32'd4);
    chk("fi_inst_after", Inst, 32'hC1);
    wait_fill(32'h0);
    chk("fi_line0_stall", 32'(n_stall), 32'd5);
    chk("fi_line0_inst", Inst, 32'hA0);
    wait_fill(32'h40);
    chk("fi_line40_stall", 32'(n_stall), 32'd5);
    chk("fi_line40_inst", Inst, 32'hB0);

    // Reset in the middle of a refill
    cyc(32'h200, 1'b0);
    chk("rr_miss", {31'd0, ICacheStall}, 32'd1);
    cyc(32'h200, 1'b0);
    chk("rr_req_before", {31'd0, MemReq}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rr_req",   {31'd0, MemReq}, 32'd0);
    chk("rr_stall", {31'd0, ICacheStall}, 32'd0);
    chk("rr_inst",  Inst, 32'h0000_0013);
    chk("rr_pc",    MemPc, 32'd0);
    wait_fill(32'h0);
    chk("rr_line0_stall", 32'(n_stall), 32'd5);
    chk("rr_line0_inst", Inst, 32'hA0);
    wait_fill(32'h40);
    chk("rr_line40_stall", 32'(n_stall), 32'd5);
    chk("rr_line40_inst", Inst, 32'hB0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
